// File: rtl/rx_word_checker.sv
// Receive-side word checker: FWFT FIFO for good words, saturating health
// counters and an incrementing-count lock tracker for the received stream.
// Ports: clk/clr (async high reset); slot_en, valid, data_in from the
// receiver; rd_en and rd_data, empty, full, level, overflow for the
// consumer; locked, good_cnt, bad_cnt, seq_err_cnt for health status.
module rx_word_checker #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16,
  parameter int LOSS_N = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              slot_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              locked,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  bad_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt
);

  localparam int MISS_W = $clog2(LOSS_N + 1);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    SEEK,
    LOCKED
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [MISS_W-1:0] miss_q, miss_d;

  logic [CNT_W-1:0]  good_q, good_d;
  logic [CNT_W-1:0]  bad_q, bad_d;
  logic [CNT_W-1:0]  seq_q, seq_d;

  logic push_req;
  logic push;
  logic pop;
  logic seq_hit;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // FIFO: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    push_req = slot_en & valid;
    pop      = rd_en & (level_q != '0);
    push     = push_req & ((level_q != FULL_LVL) | pop);
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
    if (push_req & ~push) ovf_d = 1'b1;
  end

  // Lock tracker; an invalid slot still advances the expected count.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    miss_d  = miss_q;
    seq_hit = 1'b0;
    if (slot_en) begin
      unique case (state_q)
        SEEK: begin
          if (valid) begin
            exp_d   = data_in + DATA_W'(1);
            miss_d  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (valid) begin
            seq_hit = (data_in != exp_q);
            exp_d   = data_in + DATA_W'(1);
            miss_d  = '0;
          end else begin
            exp_d  = exp_q + DATA_W'(1);
            miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(LOSS_N)) state_d = SEEK;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    seq_d  = seq_q;
    if (slot_en) begin
      if (valid) good_d = sat_inc(good_q);
      else       bad_d  = sat_inc(bad_q);
    end
    if (seq_hit) seq_d = sat_inc(seq_q);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
      state_q  <= SEEK;
      exp_q    <= '0;
      miss_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      seq_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      exp_q    <= exp_d;
      miss_q   <= miss_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      seq_q    <= seq_d;
    end
  end

  // When drained, keep presenting the last word handed to the consumer.
  assign rd_data     = (level_q == '0) ? last_q : mem_q[rd_ptr_q];
  assign empty       = (level_q == '0);
  assign full        = (level_q == FULL_LVL);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign locked      = (state_q == LOCKED);
  assign good_cnt    = good_q;
  assign bad_cnt     = bad_q;
  assign seq_err_cnt = seq_q;

endmodule

// File: tb/tb_rx_word_checker.sv
// Bench for rx_word_checker: directed scenarios plus random traffic,
// compared each cycle against a queue-based model of the channel.
module tb_rx_word_checker;

  localparam int DW    = 9;
  localparam int DEP   = 8;
  localparam int AW    = 3;
  localparam int CW    = 16;
  localparam int LOSS  = 3;
  localparam int MODV  = 1 << DW;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          clr;
  logic          slot_en;
  logic          valid;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          locked;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] bad_cnt;
  logic [CW-1:0] seq_err_cnt;

  rx_word_checker #(
    .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW),
    .CNT_W(CW), .LOSS_N(LOSS)
  ) dut (
    .clk(clk), .clr(clr), .slot_en(slot_en), .valid(valid),
    .data_in(data_in), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .level(level),
    .overflow(overflow), .locked(locked), .good_cnt(good_cnt),
    .bad_cnt(bad_cnt), .seq_err_cnt(seq_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model
  int mq[$];
  int last_m  = 0;
  bit ovf_m   = 0;
  int good_m  = 0;
  int bad_m   = 0;
  int seq_m   = 0;
  bit lk_m    = 0;
  int exp_m   = 0;
  int miss_m  = 0;
  bit did_pop;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq.delete();
      last_m = 0; ovf_m = 0; good_m = 0; bad_m = 0;
      seq_m = 0; lk_m = 0; exp_m = 0; miss_m = 0;
    end else begin
      did_pop = rd_en && mq.size() > 0;
      if (did_pop) last_m = mq.pop_front();
      if (slot_en && valid) begin
        if (mq.size() < DEP) mq.push_back(int'(data_in));
        else ovf_m = 1;
      end
      if (slot_en) begin
        if (valid) good_m = (good_m == CMAX) ? good_m : good_m + 1;
        else       bad_m  = (bad_m == CMAX) ? bad_m : bad_m + 1;
        if (!lk_m) begin
          if (valid) begin
            lk_m = 1; exp_m = (int'(data_in) + 1) % MODV; miss_m = 0;
          end
        end else if (valid) begin
          if (int'(data_in) != exp_m)
            seq_m = (seq_m == CMAX) ? seq_m : seq_m + 1;
          exp_m = (int'(data_in) + 1) % MODV; miss_m = 0;
        end else begin
          exp_m = (exp_m + 1) % MODV;
          miss_m++;
          if (miss_m == LOSS) lk_m = 0;
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!clr) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEP));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("locked", 32'(locked), 32'(lk_m));
      chk("good_cnt", 32'(good_cnt), 32'(good_m));
      chk("bad_cnt", 32'(bad_cnt), 32'(bad_m));
      chk("seq_err_cnt", 32'(seq_err_cnt), 32'(seq_m));
      chk("rd_data", 32'(rd_data),
          32'((mq.size() > 0) ? mq[0] : last_m));
    end
  end

  int pop_log[$];

  task automatic step(input bit se, input bit v, input int d,
                      input bit re);
    if (re && !empty) pop_log.push_back(int'(rd_data));
    slot_en = se; valid = v; data_in = DW'(d); rd_en = re;
    @(negedge clk);
  endtask

  // Async clear between edges; outputs must drop before any clock.
  task automatic async_clr();
    #1 clr = 1'b1;
    #2;
    chk("clr_level", 32'(level), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_full", 32'(full), 0);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_locked", 32'(locked), 0);
    chk("clr_good", 32'(good_cnt), 0);
    chk("clr_bad", 32'(bad_cnt), 0);
    chk("clr_seq", 32'(seq_err_cnt), 0);
    chk("clr_rd_data", 32'(rd_data), 0);
    #1 clr = 1'b0;
  endtask

  int fifo_exp[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 0};
  int wrap_d[5]    = '{509, 510, 511, 0, 1};
  int snap_g, snap_b, snap_s, txc;
  int last_pop;

  initial begin
    clr = 1'b0; slot_en = 0; valid = 0; data_in = '0; rd_en = 0;
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_good", 32'(good_cnt), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    clr = 1'b0;
    @(negedge clk);

    // Clean stream with continuous pops
    pop_log.delete();
    for (int i = 0; i <= 20; i++) step(1, 1, i, 1);
    step(0, 0, 0, 1);
    chk("clean_good", 32'(good_cnt), 21);
    chk("clean_bad", 32'(bad_cnt), 0);
    chk("clean_seq", 32'(seq_err_cnt), 0);
    chk("clean_locked", 32'(locked), 1);
    chk("clean_npop", 32'(pop_log.size()), 21);
    for (int i = 0; i < pop_log.size(); i++)
      chk("clean_pop", 32'(pop_log[i]), 32'(i));

    // Wrap of the count
    async_clr();
    for (int i = 0; i < 5; i++) step(1, 1, wrap_d[i], 1);
    chk("wrap_seq", 32'(seq_err_cnt), 0);
    chk("wrap_locked", 32'(locked), 1);

    // Errors, loss of lock and relock
    async_clr();
    step(1, 1, 5, 1); step(1, 1, 6, 1); step(1, 0, 0, 1);
    step(1, 1, 8, 1); step(1, 1, 9, 1);
    step(1, 1, 42, 1); step(1, 1, 43, 1);
    chk("err_bad", 32'(bad_cnt), 1);
    chk("err_seq", 32'(seq_err_cnt), 1);
    chk("err_locked", 32'(locked), 1);
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    chk("loss_still_locked", 32'(locked), 1);
    step(1, 0, 0, 1);
    chk("loss_unlocked", 32'(locked), 0);
    step(1, 1, 100, 1);
    chk("relock", 32'(locked), 1);
    chk("relock_seq", 32'(seq_err_cnt), 1);

    // FIFO full, overflow, push+pop while full, drain
    async_clr();
    pop_log.delete();
    for (int i = 0; i < 8; i++) step(1, 1, i, 0);
    chk("ff_full", 32'(full), 1);
    chk("ff_level", 32'(level), 8);
    chk("ff_ovf0", 32'(overflow), 0);
    step(1, 1, 8, 0);
    chk("ff_ovf", 32'(overflow), 1);
    chk("ff_level9", 32'(level), 8);
    step(1, 1, 9, 1);
    chk("ff_pp_level", 32'(level), 8);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("ff_empty", 32'(empty), 1);
    chk("ff_npop", 32'(pop_log.size()), 9);
    for (int i = 0; i < pop_log.size(); i++)
      chk("ff_pop", 32'(pop_log[i]), 32'(fifo_exp[i]));
    step(0, 0, 0, 1);
    chk("ff_extra_level", 32'(level), 0);
    chk("ff_extra_rd", 32'(rd_data), 9);

    // Idle slots still drain the FIFO
    for (int i = 10; i < 13; i++) step(1, 1, i, 0);
    snap_g = good_m; snap_b = bad_m; snap_s = seq_m;
    for (int i = 0; i < 10; i++) step(0, i[0], 77 + i, 1);
    chk("idle_good", 32'(good_cnt), 32'(snap_g));
    chk("idle_bad", 32'(bad_cnt), 32'(snap_b));
    chk("idle_seq", 32'(seq_err_cnt), 32'(snap_s));
    chk("idle_locked", 32'(locked), 1);
    chk("idle_empty", 32'(empty), 1);
    chk("idle_rd", 32'(rd_data), 12);

    // Random traffic
    txc = $urandom_range(0, MODV - 1);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_clr();
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 9) < 8)
          step(1, 1,
               ($urandom_range(0, 9) == 0) ?
                 int'($urandom_range(0, MODV - 1)) : txc,
               $urandom_range(0, 1) == 1);
        else
          step(1, 0, 0, $urandom_range(0, 1) == 1);
        txc = (txc + 1) % MODV;
      end else begin
        step(0, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, MODV - 1)),
             $urandom_range(0, 1) == 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
